scramble_sequencer: RTL

//  Move initiator for the 4x4 cell array. On request, issues NUM_MOVES pseudo-random
//  row/column fire moves, each spaced GAP_CYCLES apart, then returns control to the player.

---
 rtl/scramble_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/scramble_sequencer.sv
// Scramble sequencer for the 4x4 cell array.
// On a start request it issues NUM_MOVES pseudo-random row/column fire moves.
// Each move is followed by GAP_CYCLES idle cycles. When no scramble is running,
// the player's debounced move is forwarded to the cells as a single-cycle fire.
module scramble_sequencer #(
    parameter int          NUM_MOVES  = 32,
    parameter int          GAP_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       user_fire,
    input  logic       user_nRow,
    input  logic [3:0] user_row_column,
    input  logic       user_error,
    input  logic       user_add_n,
    output logic       fire,
    output logic       x_nRow,
    output logic [3:0] row_column,
    output logic       add_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] moves_issued
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FINISH} state_t;

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  MOVES_LAST = 8'(NUM_MOVES);
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [15:0] gap_cnt, gap_cnt_nxt;
    logic        start_q;

    logic        fire_nxt, x_nrow_nxt, add_n_nxt, busy_nxt, done_nxt;
    logic [3:0]  row_column_nxt;
    logic [7:0]  moves_nxt;

    // State, gap counter and the registered start request.
    // start only counts while idle, so a request made during a scramble is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= 16'd0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            start_q <= start && (state == IDLE);
        end
    end

    // Galois LFSR (shift right). It runs in every state, so the scramble depends on start timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // Next-state logic, plus the next value of every registered output.
    always_comb begin
        state_nxt      = state;
        gap_cnt_nxt    = gap_cnt;
        fire_nxt       = 1'b0;
        x_nrow_nxt     = x_nRow;
        row_column_nxt = row_column;
        add_n_nxt      = add_n;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        moves_nxt      = moves_issued;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start_q) begin
                    state_nxt = ISSUE;
                    moves_nxt = 8'd0;
                end else if (user_fire && !user_error && !start) begin
                    // A player move made in the same cycle as a start request is dropped.
                    fire_nxt       = 1'b1;
                    x_nrow_nxt     = user_nRow;
                    row_column_nxt = user_row_column;
                    add_n_nxt      = user_add_n;
                end
            end
            ISSUE: begin
                fire_nxt       = 1'b1;
                x_nrow_nxt     = lfsr[2];
                row_column_nxt = 4'b0001 << lfsr[1:0];
                add_n_nxt      = 1'b0;
                busy_nxt       = 1'b1;
                moves_nxt      = moves_issued + 8'd1;
                gap_cnt_nxt    = GAP_LOAD;
                state_nxt      = GAP;
            end
            GAP: begin
                busy_nxt = 1'b1;
                if (gap_cnt == 16'd0) begin
                    state_nxt = (moves_issued == MOVES_LAST) ? FINISH : ISSUE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 16'd1;
                end
            end
            FINISH: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers. Every output has a defined reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            fire         <= 1'b0;
            x_nRow       <= 1'b0;
            row_column   <= 4'b0001;
            add_n        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            moves_issued <= 8'd0;
        end else begin
            fire         <= fire_nxt;
            x_nRow       <= x_nrow_nxt;
            row_column   <= row_column_nxt;
            add_n        <= add_n_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            moves_issued <= moves_nxt;
        end
    end

endmodule
